// File: rtl/dcache_pkg.sv
// ============================================================================
// Module : dcache_pkg
// Brief  : Shared constants and FSM encoding for the MEM-stage data cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

  localparam int NUM_SETS      = 16;
  localparam int LINE_BITS     = 256;
  localparam int TAG_BITS      = 23;
  localparam int INDEX_BITS    = 4;
  localparam int WORD_SEL_BITS = 3;
  localparam int OFFSET_BITS   = 5;

  // Address field boundaries
  localparam int TAG_MSB   = 31;
  localparam int TAG_LSB   = 9;
  localparam int INDEX_MSB = 8;
  localparam int INDEX_LSB = 5;
  localparam int WORD_MSB  = 4;
  localparam int WORD_LSB  = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MISS       = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_READMISS   = 3'd3,
    ST_READMISSOK = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_sram.sv
// ============================================================================
// Module : dcache_sram
// Brief  : Two-way tag/valid/dirty/data storage with per-set LRU bit.
//          Combinational lookup on one index, synchronous write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_sram
  import dcache_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [INDEX_BITS-1:0]      index,
  input  logic [TAG_BITS-1:0]        lookup_tag,
  output logic                       hit,
  output logic                       hit_way,
  output logic [1:0]                 rd_valid,
  output logic [1:0]                 rd_dirty,
  output logic [1:0][TAG_BITS-1:0]   rd_tag,
  output logic [1:0][LINE_BITS-1:0]  rd_line,
  output logic                       rd_lru,
  input  logic                       wr_en,
  input  logic                       wr_way,
  input  logic [TAG_BITS-1:0]        wr_tag,
  input  logic [LINE_BITS-1:0]       wr_line,
  input  logic                       wr_dirty,
  input  logic                       lru_wr_en,
  input  logic                       lru_wr_val
);

  logic [1:0]          match;
  logic [NUM_SETS-1:0] lru_q;

  for (genvar w = 0; w < 2; w++) begin : g_way
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];
    logic                 sel;

    assign sel = wr_en && (int'(wr_way) == w);

    // Status bits: cleared on reset so every line starts invalid and clean
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= '0;
        dirty_q <= '0;
      end else if (sel) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= wr_dirty;
      end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set
    always_ff @(posedge clk_i) begin
      if (sel) begin
        tag_q[index]  <= wr_tag;
        data_q[index] <= wr_line;
      end
    end

    assign rd_valid[w] = valid_q[index];
    assign rd_dirty[w] = dirty_q[index];
    assign rd_tag[w]   = tag_q[index];
    assign rd_line[w]  = data_q[index];
    assign match[w]    = valid_q[index] && (tag_q[index] == lookup_tag);
  end

  // Way0 wins if both ways ever match
  assign hit     = |match;
  assign hit_way = ~match[0] & match[1];
  assign rd_lru  = lru_q[index];

  // LRU bit names the way to evict next when both ways are valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lru_q <= '0;
    end else if (lru_wr_en) begin
      lru_q[index] <= lru_wr_val;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
// ============================================================================
// Module : dcache_controller
// Brief  : MEM-stage 2-way write-back, write-allocate data cache with LRU
//          replacement; stalls the pipeline while a miss is serviced.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_controller
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  state_t                    state_q, state_d;
  logic [TAG_BITS-1:0]       req_tag, miss_tag_q;
  logic [INDEX_BITS-1:0]     req_index, miss_index_q, lookup_index;
  logic [WORD_SEL_BITS-1:0]  req_word;
  logic                      victim_q, victim_way;

  logic                      hit, hit_way, rd_lru;
  logic [1:0]                rd_valid, rd_dirty;
  logic [1:0][TAG_BITS-1:0]  rd_tag;
  logic [1:0][LINE_BITS-1:0] rd_line;
  logic [LINE_BITS-1:0]      hit_line, wr_line;
  logic [TAG_BITS-1:0]       wr_tag;
  logic                      wr_en, wr_way, wr_dirty, lru_wr_en, lru_wr_val;
  logic                      capture_miss, start_wb, start_fill;

  logic                      mem_enable_q, mem_write_q;
  logic [31:0]               mem_addr_q;
  logic [LINE_BITS-1:0]      mem_data_q;
  logic                      unused_addr_bits;

  assign req_tag          = cpu_addr_i[TAG_MSB:TAG_LSB];
  assign req_index        = cpu_addr_i[INDEX_MSB:INDEX_LSB];
  assign req_word         = cpu_addr_i[WORD_MSB:WORD_LSB];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // Outside IDLE the set under service is the one captured at the miss
  assign lookup_index = (state_q == ST_IDLE) ? req_index : miss_index_q;
  assign hit_line     = rd_line[hit_way];
  assign victim_way   = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .index      (lookup_index),
    .lookup_tag (req_tag),
    .hit        (hit),
    .hit_way    (hit_way),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .rd_lru     (rd_lru),
    .wr_en      (wr_en),
    .wr_way     (wr_way),
    .wr_tag     (wr_tag),
    .wr_line    (wr_line),
    .wr_dirty   (wr_dirty),
    .lru_wr_en  (lru_wr_en),
    .lru_wr_val (lru_wr_val)
  );

  // State register plus the miss context (set, tag, victim) held for the whole miss
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      victim_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture_miss) begin
        miss_tag_q   <= req_tag;
        miss_index_q <= req_index;
        victim_q     <= victim_way;
      end
    end
  end

  // Next-state, hit handling, array writes and stall generation
  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b1;
    cpu_data_o   = '0;
    wr_en        = 1'b0;
    wr_way       = hit_way;
    wr_tag       = req_tag;
    wr_line      = hit_line;
    wr_dirty     = 1'b1;
    lru_wr_en    = 1'b0;
    lru_wr_val   = ~hit_way;
    capture_miss = 1'b0;
    start_wb     = 1'b0;
    start_fill   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_stall_o = 1'b0;
        if (cpu_req_i) begin
          if (hit) begin
            lru_wr_en = 1'b1;
            if (cpu_write_i) begin
              wr_en = 1'b1;
              wr_line[{req_word, 5'b0} +: 32] = cpu_data_i;
            end else begin
              cpu_data_o = hit_line[{req_word, 5'b0} +: 32];
            end
          end else begin
            cpu_stall_o  = 1'b1;
            capture_miss = 1'b1;
            state_d      = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (rd_valid[victim_q] && rd_dirty[victim_q]) begin
          start_wb = 1'b1;
          state_d  = ST_WRITEBACK;
        end else begin
          start_fill = 1'b1;
          state_d    = ST_READMISS;
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack_i) begin
          start_fill = 1'b1;
          state_d    = ST_READMISS;
        end
      end
      ST_READMISS: begin
        if (mem_ack_i) begin
          wr_en    = 1'b1;
          wr_way   = victim_q;
          wr_tag   = miss_tag_q;
          wr_line  = mem_data_i;
          wr_dirty = 1'b0;
          state_d  = ST_READMISSOK;
        end
      end
      ST_READMISSOK: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Registered memory request: one-cycle enable, address/data/direction held until the next request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      mem_enable_q <= start_wb | start_fill;
      if (start_wb) begin
        mem_write_q <= 1'b1;
        mem_addr_q  <= {rd_tag[victim_q], miss_index_q, {OFFSET_BITS{1'b0}}};
        mem_data_q  <= rd_line[victim_q];
      end else if (start_fill) begin
        mem_write_q <= 1'b0;
        mem_addr_q  <= {miss_tag_q, miss_index_q, {OFFSET_BITS{1'b0}}};
      end
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_controller.sv
// ============================================================================
// Module : tb_dcache_controller
// Brief  : Directed self-checking bench for dcache_controller with a
//          behavioural line memory that acks two cycles after each request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // Memory model state and request log
  logic [255:0] mem_model [logic [31:0]];
  bit           auto_ack = 1'b1;
  bit           stray_ack = 1'b0;
  int           cnt = 0, ack_cyc = 0, seq = 0;
  int           wb_count = 0, fill_count = 0, wb_seq = 0, fill_seq = 0;
  logic [31:0]  last_wb_addr = '0, last_fill_addr = '0, pend_addr = '0;
  logic [255:0] last_wb_data = '0, pend_data = '0;
  bit           pend_wr = 1'b0;

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Cycle counter used to measure ack-to-release distance
  always @(posedge clk_i) cycle++;

  function automatic logic [255:0] pattern_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 8'hA5, 5'b0, 3'(k)};
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pattern_line(a);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: logs each request pulse and acks it two cycles later
  initial begin : responder
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (stray_ack) begin
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'hBAD0BAD0}};
        stray_ack  = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_ack_i = 1'b1;
          ack_cyc   = cycle;
          if (pend_wr) mem_model[pend_addr] = pend_data;
          else         mem_data_i = line_of(pend_addr);
        end
      end
      if (mem_enable_o === 1'b1) begin
        seq++;
        if (mem_write_o) begin
          wb_count++; wb_seq = seq;
          last_wb_addr = mem_addr_o; last_wb_data = mem_data_o;
        end else begin
          fill_count++; fill_seq = seq;
          last_fill_addr = mem_addr_o;
        end
        if (auto_ack) begin
          cnt = 2; pend_wr = mem_write_o; pend_addr = mem_addr_o; pend_data = mem_data_o;
        end
      end
    end
  end

  // One CPU access; returns the data seen in the completing cycle and stall timing
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stall_cycles,
                        output logic first_stall, output int drop_cyc);
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d;
    #1;
    first_stall  = cpu_stall_o;
    stall_cycles = 0;
    while (cpu_stall_o && stall_cycles < 200) begin
      @(negedge clk_i); #1;
      stall_cycles++;
    end
    if (stall_cycles >= 200) chk("access_timeout", 256'(stall_cycles), 256'(0));
    rd       = cpu_data_o;
    drop_cyc = cycle;
  endtask

  logic [31:0]  rd;
  int           sc, dc, wb0, fc0, n;
  logic         fs;
  logic [255:0] tmp;

  initial begin
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    tmp = pattern_line(32'h100);
    tmp[31:0] = 32'hDEADBEEF;
    mem_model[32'h100] = tmp;

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_stall",   256'(cpu_stall_o),  256'(0));
    chk("rst_data",    256'(cpu_data_o),   256'(0));
    chk("rst_mem_en",  256'(mem_enable_o), 256'(0));
    chk("rst_mem_wr",  256'(mem_write_o),  256'(0));
    chk("rst_mem_adr", 256'(mem_addr_o),   256'(0));
    chk("rst_mem_dat", mem_data_o,         256'(0));
    @(negedge clk_i) rst_i = 1'b0;

    // 1: cold load miss
    access(1'b0, 32'h100, 32'h0, rd, sc, fs, dc);
    chk("t1_stall_now",  256'(fs),             256'(1));
    chk("t1_fill_cnt",   256'(fill_count),     256'(1));
    chk("t1_wb_cnt",     256'(wb_count),       256'(0));
    chk("t1_fill_addr",  256'(last_fill_addr), 256'(32'h100));
    chk("t1_load",       256'(rd),             256'(32'hDEADBEEF));
    chk("t1_ack_to_rel", 256'(dc - ack_cyc),   256'(2));

    // 2: store hit then load hit
    access(1'b1, 32'h104, 32'h12345678, rd, sc, fs, dc);
    chk("t2_st_nostall", 256'(sc), 256'(0));
    chk("t2_st_data0",   256'(rd), 256'(0));
    access(1'b0, 32'h104, 32'h0, rd, sc, fs, dc);
    chk("t2_ld_nostall", 256'(sc), 256'(0));
    chk("t2_ld_data",    256'(rd), 256'(32'h12345678));

    // 3: fill other way, then evict the dirty LRU line
    wb0 = wb_count;
    access(1'b0, 32'h300, 32'h0, rd, sc, fs, dc);
    chk("t3a_miss",      256'(sc != 0),        256'(1));
    chk("t3a_no_wb",     256'(wb_count),       256'(wb0));
    chk("t3a_fill_addr", 256'(last_fill_addr), 256'(32'h300));
    chk("t3a_load",      256'(rd),             256'(32'h0300A500));
    access(1'b0, 32'h500, 32'h0, rd, sc, fs, dc);
    chk("t3b_wb_cnt",    256'(wb_count),          256'(wb0 + 1));
    chk("t3b_wb_addr",   256'(last_wb_addr),      256'(32'h100));
    chk("t3b_wb_word1",  256'(last_wb_data[63:32]), 256'(32'h12345678));
    chk("t3b_wb_word0",  256'(last_wb_data[31:0]),  256'(32'hDEADBEEF));
    chk("t3b_fill_addr", 256'(last_fill_addr),    256'(32'h500));
    chk("t3b_wb_first",  256'(fill_seq > wb_seq), 256'(1));
    chk("t3b_load",      256'(rd),                256'(32'h0500A500));

    // 4: LRU honoured, clean victim needs no write-back
    access(1'b0, 32'h300, 32'h0, rd, sc, fs, dc);
    chk("t4_hit300",     256'(sc), 256'(0));
    chk("t4_hit300_dat", 256'(rd), 256'(32'h0300A500));
    wb0 = wb_count;
    access(1'b0, 32'h700, 32'h0, rd, sc, fs, dc);
    chk("t4_miss700",    256'(sc != 0),        256'(1));
    chk("t4_no_wb",      256'(wb_count),       256'(wb0));
    chk("t4_fill_addr",  256'(last_fill_addr), 256'(32'h700));
    access(1'b0, 32'h300, 32'h0, rd, sc, fs, dc);
    chk("t4_300_kept",   256'(sc), 256'(0));
    access(1'b0, 32'h500, 32'h0, rd, sc, fs, dc);
    chk("t4_500_evicted", 256'(sc != 0), 256'(1));
    chk("t4_no_wb2",      256'(wb_count), 256'(wb0));

    // 5: reset during READMISS, stray ack afterwards
    auto_ack = 1'b0;
    fc0 = fill_count;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h100;
    n = 0;
    #1;
    while (!(mem_enable_o === 1'b1) && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    chk("t5_rm_reached", 256'(n < 50),      256'(1));
    chk("t5_rm_write",   256'(mem_write_o), 256'(0));
    chk("t5_rm_addr",    256'(mem_addr_o),  256'(32'h100));
    @(negedge clk_i);
    rst_i = 1'b1; cpu_req_i = 1'b0;
    #1;
    chk("t5_rst_stall",  256'(cpu_stall_o), 256'(0));
    chk("t5_rst_addr",   256'(mem_addr_o),  256'(0));
    @(negedge clk_i) rst_i = 1'b0;
    @(negedge clk_i) stray_ack = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk("t5_ack_stall",  256'(cpu_stall_o),  256'(0));
    chk("t5_ack_mem_en", 256'(mem_enable_o), 256'(0));
    auto_ack = 1'b1;
    wb0 = wb_count;
    access(1'b0, 32'h100, 32'h0, rd, sc, fs, dc);
    chk("t5_remiss",     256'(sc != 0),   256'(1));
    chk("t5_no_wb",      256'(wb_count),  256'(wb0));
    chk("t5_fill_cnt",   256'(fill_count), 256'(fc0 + 2));
    chk("t5_load",       256'(rd),        256'(32'hDEADBEEF));
    access(1'b0, 32'h104, 32'h0, rd, sc, fs, dc);
    chk("t5_wb_saved",   256'(rd),        256'(32'h12345678));

    // 6: store miss allocates and merges
    access(1'b1, 32'h908, 32'hABCD0000, rd, sc, fs, dc);
    chk("t6_miss",       256'(sc != 0),        256'(1));
    chk("t6_fill_addr",  256'(last_fill_addr), 256'(32'h900));
    access(1'b0, 32'h908, 32'h0, rd, sc, fs, dc);
    chk("t6_merged",     256'(rd), 256'(32'hABCD0000));
    chk("t6_hit",        256'(sc), 256'(0));
    access(1'b0, 32'h900, 32'h0, rd, sc, fs, dc);
    chk("t6_word0",      256'(rd), 256'(32'h0900A500));
    access(1'b0, 32'h91C, 32'h0, rd, sc, fs, dc);
    chk("t6_word7",      256'(rd), 256'(32'h0900A507));

    // Request dropped mid-miss: fill completes, store is not performed
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = 1'b1; cpu_addr_i = 32'hA04; cpu_data_i = 32'h55555555;
    repeat (2) @(negedge clk_i);
    cpu_req_i = 1'b0;
    n = 0;
    #1;
    while (cpu_stall_o && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    chk("drop_released", 256'(n < 50), 256'(1));
    access(1'b0, 32'hA04, 32'h0, rd, sc, fs, dc);
    chk("drop_filled",   256'(sc), 256'(0));
    chk("drop_no_store", 256'(rd), 256'(32'h0A00A501));

    @(negedge clk_i) cpu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
